// File: rtl/calc_sequencer.sv
// Calculator sequencer: op-code register, result capture and
// val_bcd start/ready handshake, plus display source select.
module calc_sequencer #(
  parameter int NUM_OPS      = 8,
  parameter int LOGIC_OPS    = 4,
  parameter int SUB_OP       = 5,
  parameter int CONV_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enter_p,
  input  logic        back_p,
  input  logic        up_p,
  input  logic        down_p,
  input  logic [7:0]  calc_result,
  input  logic        bcd_rdy,
  output logic [2:0]  op,
  output logic        conv_start,
  output logic [11:0] conv_value,
  output logic        neg,
  output logic [1:0]  disp_sel,
  output logic        busy,
  output logic        err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_OP_SEL,
    S_LOAD,
    S_CONV,
    S_RESULT
  } state_t;

  state_t      state, state_d;
  logic [2:0]  op_d;
  logic [11:0] val_d;
  logic        neg_d;
  logic        err_d;
  logic        have_q, have_d;
  logic [7:0]  cnt, cnt_d;
  logic        start_d;
  logic [1:0]  disp_d;
  logic        busy_d;
  logic        nav;
  logic        is_logic;
  logic        is_sub;

  assign nav      = up_p ^ down_p;
  assign is_logic = ({29'b0, op} < LOGIC_OPS);
  assign is_sub   = ({29'b0, op} == SUB_OP);

  always_comb begin
    state_d = state;
    op_d    = op;
    val_d   = conv_value;
    neg_d   = neg;
    err_d   = err;
    have_d  = have_q;
    cnt_d   = cnt;
    start_d = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (enter_p)
          state_d = S_LOAD;
        else if (!back_p && nav)
          state_d = S_OP_SEL;
      end
      S_OP_SEL: begin
        if (enter_p)
          state_d = S_LOAD;
        else if (back_p)
          state_d = have_q ? S_RESULT : S_IDLE;
        else if (up_p && !down_p)
          op_d = (op == 3'(NUM_OPS - 1)) ? 3'd0 : op + 3'd1;
        else if (down_p && !up_p)
          op_d = (op == 3'd0) ? 3'(NUM_OPS - 1) : op - 3'd1;
      end
      S_LOAD: begin
        if (is_logic) begin
          val_d = 12'd1000 * 12'(calc_result[3])
                + 12'd100 * 12'(calc_result[2])
                + 12'd10 * 12'(calc_result[1])
                + 12'(calc_result[0]);
          neg_d = 1'b0;
        end else if (is_sub && calc_result[7]) begin
          val_d = {4'b0, ~calc_result + 8'd1};
          neg_d = 1'b1;
        end else begin
          val_d = {4'b0, calc_result};
          neg_d = 1'b0;
        end
        err_d   = 1'b0;
        cnt_d   = 8'd1;
        start_d = 1'b1;
        state_d = S_CONV;
      end
      S_CONV: begin
        // cnt==1 is the start cycle; bcd_rdy is stale there
        if (cnt != 8'd1 && bcd_rdy) begin
          state_d = S_RESULT;
          have_d  = 1'b1;
          cnt_d   = 8'd0;
        end else if (cnt == 8'(CONV_TIMEOUT)) begin
          state_d = S_IDLE;
          err_d   = 1'b1;
          have_d  = 1'b0;
          cnt_d   = 8'd0;
        end else begin
          cnt_d = cnt + 8'd1;
        end
      end
      S_RESULT: begin
        if (enter_p)
          state_d = S_LOAD;
        else if (back_p)
          state_d = S_IDLE;
        else if (nav)
          state_d = S_OP_SEL;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    disp_d = 2'd0;
    busy_d = 1'b0;
    unique case (state_d)
      S_OP_SEL: disp_d = 2'd1;
      S_LOAD, S_CONV: begin
        disp_d = 2'd1;
        busy_d = 1'b1;
      end
      S_RESULT: disp_d = 2'd2;
      default: disp_d = 2'd0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      op         <= 3'd0;
      conv_value <= 12'd0;
      neg        <= 1'b0;
      err        <= 1'b0;
      have_q     <= 1'b0;
      cnt        <= 8'd0;
      conv_start <= 1'b0;
      disp_sel   <= 2'd0;
      busy       <= 1'b0;
    end else begin
      state      <= state_d;
      op         <= op_d;
      conv_value <= val_d;
      neg        <= neg_d;
      err        <= err_d;
      have_q     <= have_d;
      cnt        <= cnt_d;
      conv_start <= start_d;
      disp_sel   <= disp_d;
      busy       <= busy_d;
    end
  end

endmodule

// File: tb/tb_calc_sequencer.sv
// Bench for calc_sequencer: scoreboard on conv_start against a
// decimal/sign reference model, plus navigation and timeout checks.
module tb_calc_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        enter_p, back_p, up_p, down_p;
  logic [7:0]  calc_result;
  logic        bcd_rdy;
  logic [2:0]  op;
  logic        conv_start;
  logic [11:0] conv_value;
  logic        neg;
  logic [1:0]  disp_sel;
  logic        busy;
  logic        err;

  typedef struct {
    int val;
    int neg;
  } exp_t;

  exp_t q[$];
  int   checks   = 0;
  int   failures = 0;
  int   exp_op   = 0;
  int   pushed   = 0;
  int   popped   = 0;
  exp_t last;

  calc_sequencer dut (
    .clk(clk),
    .rst(rst),
    .enter_p(enter_p),
    .back_p(back_p),
    .up_p(up_p),
    .down_p(down_p),
    .calc_result(calc_result),
    .bcd_rdy(bcd_rdy),
    .op(op),
    .conv_start(conv_start),
    .conv_value(conv_value),
    .neg(neg),
    .disp_sel(disp_sel),
    .busy(busy),
    .err(err)
  );

  always #5 clk = ~clk;

  function automatic void chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endfunction

  function automatic exp_t model(int o, logic [7:0] r);
    exp_t e;
    e.neg = 0;
    if (o < 4) begin
      e.val = 0;
      for (int i = 3; i >= 0; i--)
        e.val = e.val * 10 + int'(r[i]);
    end else if (o == 5 && $signed(r) < 0) begin
      e.val = -int'($signed(r));
      e.neg = 1;
    end else begin
      e.val = int'(r);
    end
    return e;
  endfunction

  always @(negedge clk) begin
    if (!rst && conv_start) begin
      if (q.size() == 0) begin
        chk("sb_unexpected_start", 1, 0);
      end else begin
        exp_t e;
        e = q.pop_front();
        popped++;
        chk("sb_conv_value", int'(conv_value), e.val);
        chk("sb_neg", int'(neg), e.neg);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic press(input logic e, input logic b,
                       input logic u, input logic d);
    enter_p = e;
    back_p  = b;
    up_p    = u;
    down_p  = d;
    step();
    enter_p = 1'b0;
    back_p  = 1'b0;
    up_p    = 1'b0;
    down_p  = 1'b0;
  endtask

  task automatic goto_op(input int t, input bit dn);
    if (disp_sel != 2'd1) begin
      press(0, 0, 1, 0);
      chk("opsel_entry_disp", int'(disp_sel), 1);
      chk("opsel_entry_op", int'(op), exp_op);
    end
    while (exp_op != t) begin
      if (dn) begin
        press(0, 0, 0, 1);
        exp_op = (exp_op + 7) % 8;
      end else begin
        press(0, 0, 1, 0);
        exp_op = (exp_op + 1) % 8;
      end
    end
    chk("goto_op", int'(op), exp_op);
  endtask

  // enter and let the conversion start; returns in first CONV cycle
  task automatic start_calc(input logic [7:0] r, input bit both);
    calc_result = r;
    last = model(exp_op, r);
    q.push_back(last);
    pushed++;
    press(1, 0, both, 0);
    chk("load_busy", int'(busy), 1);
    chk("load_disp", int'(disp_sel), 1);
    begin
      int n = 0;
      while (!conv_start && n < 5) begin
        step();
        n++;
      end
      chk("conv_start_seen", int'(conv_start), 1);
    end
  endtask

  task automatic finish_calc(input int d);
    repeat (d) step();
    bcd_rdy = 1'b1;
    step();
    bcd_rdy = 1'b0;
    chk("result_disp", int'(disp_sel), 2);
    chk("result_busy", int'(busy), 0);
    chk("result_err", int'(err), 0);
    chk("result_op", int'(op), exp_op);
    step();
    chk("hold_value", int'(conv_value), last.val);
    chk("hold_neg", int'(neg), last.neg);
  endtask

  initial begin
    rst = 1'b1;
    enter_p = 0; back_p = 0; up_p = 0; down_p = 0;
    calc_result = 8'd0;
    bcd_rdy = 1'b0;
    #1;
    chk("rst_op", int'(op), 0);
    chk("rst_disp", int'(disp_sel), 0);
    chk("rst_outs", int'({conv_start, conv_value, neg, busy, err}), 0);
    step();
    step();
    rst = 1'b0;
    step();

    // op wrap upward then downward
    press(0, 0, 1, 0);
    chk("t1_entry_disp", int'(disp_sel), 1);
    chk("t1_entry_op", int'(op), 0);
    for (int i = 1; i <= 8; i++) begin
      press(0, 0, 1, 0);
      exp_op = i % 8;
      chk("t1_up_op", int'(op), exp_op);
    end
    press(0, 0, 0, 1);
    exp_op = 7;
    chk("t1_down_wrap", int'(op), 7);
    press(0, 0, 1, 1);
    chk("t1_updown_noop", int'(op), 7);

    // logic op shown as binary digits
    goto_op(2, 1'b1);
    start_calc(8'b0000_1011, 1'b0);
    finish_calc(9);

    // subtraction sign handling
    goto_op(5, 1'b0);
    start_calc(8'hFD, 1'b0);
    finish_calc(3);
    press(1, 0, 0, 0);
    calc_result = 8'h80;
    last = model(5, 8'h80);
    q.push_back(last);
    pushed++;
    step();
    begin
      int n = 0;
      while (!conv_start && n < 5) begin
        step();
        n++;
      end
    end
    finish_calc(1);

    // timeout
    begin
      int n = 0;
      goto_op(6, 1'b0);
      start_calc(8'd200, 1'b0);
      n = 1;
      while (busy && n < 400) begin
        step();
        n++;
      end
      chk("t4_busy_cycles", n, 256);
      chk("t4_err", int'(err), 1);
      chk("t4_disp", int'(disp_sel), 0);
      press(0, 0, 1, 0);
      chk("t4_opsel", int'(disp_sel), 1);
      press(0, 1, 0, 0);
      chk("t4_back_idle", int'(disp_sel), 0);
      chk("t4_err_sticky", int'(err), 1);
    end

    // enter+up together, then pulses ignored during CONV
    goto_op(3, 1'b0);
    start_calc(8'h5A, 1'b1);
    chk("t5_op_same", int'(op), 3);
    press(0, 0, 1, 0);
    press(0, 0, 0, 1);
    press(0, 1, 0, 0);
    press(1, 0, 0, 0);
    chk("t5_still_busy", int'(busy), 1);
    chk("t5_op_kept", int'(op), 3);
    finish_calc(1);

    // random ops, operands and ready delays
    for (int k = 0; k < 14; k++) begin
      goto_op(int'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
      start_calc(8'($urandom), 1'b0);
      finish_calc(int'($urandom_range(1, 15)));
      if ($urandom_range(0, 3) == 0) begin
        press(0, 1, 0, 0);
        chk("rnd_back_idle", int'(disp_sel), 0);
      end
    end

    // reset in the middle of a conversion
    goto_op(7, 1'b0);
    start_calc(8'd42, 1'b0);
    step();
    #2;
    rst = 1'b1;
    #1;
    chk("t6_op", int'(op), 0);
    chk("t6_disp", int'(disp_sel), 0);
    chk("t6_outs", int'({conv_start, conv_value, neg, busy, err}), 0);
    exp_op = 0;
    step();
    rst = 1'b0;
    step();
    step();
    chk("t6_idle", int'({busy, disp_sel}), 0);

    chk("sb_drained", q.size(), 0);
    chk("sb_count", popped, pushed);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
